// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button synchronise/debounce, press-event
// generation and the start/stop/lap/clear FSM driving the counter chain.
module stopwatch_ctrl #(
  parameter int unsigned DEB_COUNT = 1000000,
  parameter int unsigned DEB_W     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic       tick,
  input  logic       cnt_max,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       running,
  output logic [2:0] state
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LAP   = 3'd3,
    S_FULL  = 3'd4
  } state_e;

  // Button lanes: bit 0 = start/stop, bit 1 = lap, bit 2 = clear.
  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       deb_q, deb_d, deb_prev_q;
  logic [2:0]       ev_q;
  logic [DEB_W-1:0] cnt_q [3];
  logic [DEB_W-1:0] cnt_d [3];

  state_e state_q, state_d;
  logic   clr_d, cnt_clr_q, running_q, hold_q;
  logic   ev_clr, ev_ss, ev_lap, full_hit;

  assign raw = {btn_clr, btn_lap, btn_ss};

  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + DEB_W'(1);
      end
    end
  end

  // The press event compares the debounced level with its own delayed copy,
  // which places the FSM's reaction DEB_COUNT+3 edges after the first sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      ev_q       <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      ev_q       <= deb_q & ~deb_prev_q;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Only the highest-priority event survives: clr > ss > lap.
  assign ev_clr   = ev_q[2];
  assign ev_ss    = ev_q[0] & ~ev_q[2];
  assign ev_lap   = ev_q[1] & ~ev_q[0] & ~ev_q[2];
  assign full_hit = tick & cnt_max;

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_clr)     clr_d   = 1'b1;
        else if (ev_ss) state_d = S_RUN;
      end
      S_RUN: begin
        if (ev_ss)         state_d = S_PAUSE;
        else if (ev_lap)   state_d = S_LAP;
        else if (full_hit) state_d = S_FULL;
      end
      S_LAP: begin
        if (ev_ss)         state_d = S_PAUSE;
        else if (ev_lap)   state_d = S_RUN;
        else if (full_hit) state_d = S_FULL;
      end
      S_PAUSE: begin
        if (ev_clr) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end else if (ev_ss) begin
          state_d = S_RUN;
        end
      end
      S_FULL: begin
        if (ev_clr) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_clr_q <= 1'b0;
      running_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_clr_q <= clr_d;
      running_q <= (state_d == S_RUN) || (state_d == S_LAP);
      hold_q    <= (state_d == S_LAP);
    end
  end

  assign cnt_en    = tick & running_q & ~cnt_max;
  assign cnt_clr   = cnt_clr_q;
  assign disp_hold = hold_q;
  assign running   = running_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed vector table, corner-case
// sequences and random stimulus against a sample-history reference model.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
  logic       tick = 1'b0, cnt_max = 1'b0;
  logic       cnt_en, cnt_clr, disp_hold, running;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  stopwatch_ctrl #(.DEB_COUNT(4), .DEB_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_ss    (btn_ss),
    .btn_lap   (btn_lap),
    .btn_clr   (btn_clr),
    .tick      (tick),
    .cnt_max   (cnt_max),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .disp_hold (disp_hold),
    .running   (running),
    .state     (state)
  );

  initial forever #5 clk = ~clk;

  // Reference model: a level is accepted once the last DEB_COUNT synchronised
  // samples all disagree with it; the FSM reacts two edges after acceptance.
  bit         hist [3][$];
  logic [2:0] m_deb;
  logic [2:0] evq [$];
  int         m_state;
  bit         m_clr;

  function automatic void model_reset();
    for (int b = 0; b < 3; b++) begin
      hist[b].delete();
      repeat (6) hist[b].push_back(1'b0);
    end
    m_deb = '0;
    evq.delete();
    evq.push_back(3'b000);
    evq.push_back(3'b000);
    m_state = 0;
    m_clr   = 1'b0;
  endfunction

  function automatic void model_step();
    logic [2:0] ev, raw, rise;
    int  top;
    bit  full, differ;
    ev   = evq.pop_front();
    raw  = {btn_clr, btn_lap, btn_ss};
    top  = ev[2] ? 2 : ev[0] ? 0 : ev[1] ? 1 : -1;
    full = tick && cnt_max;
    m_clr = 1'b0;
    case (m_state)
      0: if (top == 2) m_clr = 1'b1; else if (top == 0) m_state = 1;
      1, 3: begin
        if (top == 0)      m_state = 2;
        else if (top == 1) m_state = (m_state == 1) ? 3 : 1;
        else if (full)     m_state = 4;
      end
      2: if (top == 2) begin m_state = 0; m_clr = 1'b1; end
         else if (top == 0) m_state = 1;
      4: if (top == 2) begin m_state = 0; m_clr = 1'b1; end
      default: m_state = 0;
    endcase
    rise = '0;
    for (int b = 0; b < 3; b++) begin
      hist[b].push_back(raw[b]);
      void'(hist[b].pop_front());
      differ = 1'b1;
      for (int j = 0; j < 4; j++) if (hist[b][j] == m_deb[b]) differ = 1'b0;
      if (differ) begin
        if (!m_deb[b]) rise[b] = 1'b1;
        m_deb[b] = ~m_deb[b];
      end
    end
    evq.push_back(rise);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, then compare all outputs to the model.
  task automatic cyc(input logic ss, input logic lap, input logic clr,
                     input logic tk, input logic mx);
    logic [7:0] exp;
    bit run;
    @(negedge clk);
    btn_ss = ss; btn_lap = lap; btn_clr = clr; tick = tk; cnt_max = mx;
    #1;
    run = (m_state == 1) || (m_state == 3);
    exp = {1'b0, 3'(m_state), run, (m_state == 3), tk & run & ~mx, m_clr};
    check("model", {1'b0, state, running, disp_hold, cnt_en, cnt_clr}, exp);
  endtask

  task automatic hold(input logic ss, input logic lap, input logic clr,
                      input logic tk, input logic mx, input int n);
    repeat (n) cyc(ss, lap, clr, tk, mx);
  endtask

  typedef struct {
    logic ss, lap, clr, tk, mx;
    int   n;
    logic [2:0] st;
    logic en, cc, hd, run;
  } vec_t;

  function automatic vec_t mk(input int ss, lap, clr, tk, mx, n, st, en, cc, hd, run);
    vec_t v;
    v.ss = 1'(ss); v.lap = 1'(lap); v.clr = 1'(clr); v.tk = 1'(tk); v.mx = 1'(mx);
    v.n = n; v.st = 3'(st); v.en = 1'(en); v.cc = 1'(cc); v.hd = 1'(hd); v.run = 1'(run);
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    //                ss lap clr tk mx   n  st en cc hd run
    tbl.push_back(mk(0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0));  // short glitch
    tbl.push_back(mk(0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,  9, 1, 0, 0, 0, 1));  // IDLE->RUN after 7 edges
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,  4, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,  4, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0,  9, 3, 0, 0, 1, 1));  // RUN->LAP
    tbl.push_back(mk(0, 1, 0, 1, 0,  1, 3, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12, 3, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0,  9, 1, 0, 0, 0, 1));  // LAP->RUN
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  9, 2, 0, 0, 0, 0));  // RUN->PAUSE
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  8, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 0, 0, 1, 0, 0));  // PAUSE->IDLE, clear pulse
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,  9, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1,  1, 1, 0, 0, 0, 1));  // terminal tick
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 4, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,  9, 4, 0, 0, 0, 0));  // ss ignored in FULL
    tbl.push_back(mk(0, 0, 0, 1, 0, 12, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  9, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0));

    model_reset();

    // Reset held with buttons toggling.
    for (int i = 0; i < 6; i++) cyc(1'(i), 1'(i + 1), 1'(i >> 1), 1'(i), 1'b0);
    hold(0, 0, 0, 0, 0, 2);
    check("reset_outputs", {1'b0, state, running, disp_hold, cnt_en, cnt_clr}, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      hold(tbl[i].ss, tbl[i].lap, tbl[i].clr, tbl[i].tk, tbl[i].mx, tbl[i].n);
      check($sformatf("vec%0d", i),
            {1'b0, state, cnt_en, cnt_clr, disp_hold, running},
            {1'b0, tbl[i].st, tbl[i].en, tbl[i].cc, tbl[i].hd, tbl[i].run});
    end

    // Tick coinciding with the ss event that leaves RUN still counts.
    hold(1, 0, 0, 0, 0, 9);
    hold(0, 0, 0, 0, 0, 12);
    hold(1, 0, 0, 0, 0, 7);
    cyc(1, 0, 0, 1, 0);
    check("tick_on_leave_en", {7'd0, cnt_en}, 8'h01);
    cyc(0, 0, 0, 0, 0);
    check("tick_on_leave_state", {5'd0, state}, 8'h02);
    hold(0, 0, 0, 0, 0, 12);

    // clr and ss together in PAUSE: clr wins.
    hold(1, 0, 1, 0, 0, 9);
    check("clr_wins_state", {5'd0, state}, 8'h00);
    check("clr_wins_pulse", {7'd0, cnt_clr}, 8'h01);
    hold(0, 0, 0, 0, 0, 12);
    check("ss_discarded", {5'd0, state}, 8'h00);

    // Reset mid-debounce in RUN, with ss held across reset release.
    hold(1, 0, 0, 0, 0, 9);
    hold(0, 0, 0, 0, 0, 12);
    check("pre_reset_run", {5'd0, state}, 8'h01);
    hold(1, 0, 0, 0, 0, 3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_reset", {1'b0, state, running, disp_hold, cnt_en, cnt_clr}, 8'h00);
    hold(1, 0, 0, 0, 0, 2);
    @(negedge clk);
    reset = 1'b1;
    hold(1, 0, 0, 0, 0, 7);
    check("held_across_reset_early", {5'd0, state}, 8'h00);
    cyc(1, 0, 0, 0, 0);
    check("held_across_reset_event", {5'd0, state}, 8'h01);
    hold(0, 0, 0, 0, 0, 12);

    // Random stimulus against the model.
    begin
      int   left [3];
      logic val  [3];
      for (int b = 0; b < 3; b++) begin left[b] = 0; val[b] = 1'b0; end
      for (int c = 0; c < 4000; c++) begin
        for (int b = 0; b < 3; b++) begin
          if (left[b] == 0) begin
            val[b]  = 1'($urandom_range(0, 1));
            left[b] = $urandom_range(1, 12);
          end
          left[b]--;
        end
        cyc(val[0], val[1], val[2], 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 19) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
